// File: rtl/ex_mdu.sv
// RV32M multiply/divide unit for the EX stage: single-cycle-registered multiply,
// 32-step restoring divide with sign fix-up, and stall/done handshake to the pipeline.
module ex_mdu (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_DIV  = 3'd2;
  localparam logic [2:0] S_FIX  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  logic [2:0]  r_state;
  logic [2:0]  r_f3;
  logic [31:0] r_a, r_b;
  logic [31:0] r_rem, r_quo, r_dvs;
  logic [4:0]  r_cnt;
  logic        r_neg_q, r_neg_r;
  logic [31:0] r_result;

  // Accept-time decode, taken straight from the input operands
  logic        w_accept, w_sgn, w_b_zero, w_ovf, w_bypass;
  logic [31:0] w_abs_a, w_abs_b, w_byp_res;

  assign w_accept  = (r_state == S_IDLE) && start && !flush;
  assign w_sgn     = !funct3[0];
  assign w_b_zero  = (op_b == 32'h0);
  assign w_ovf     = w_sgn && (op_a == 32'h8000_0000) && (op_b == 32'hFFFF_FFFF);
  assign w_bypass  = w_b_zero || w_ovf;
  assign w_abs_a   = (w_sgn && op_a[31]) ? -op_a : op_a;
  assign w_abs_b   = (w_sgn && op_b[31]) ? -op_b : op_b;
  assign w_byp_res = funct3[1] ? (w_b_zero ? op_a : 32'h0)
                               : (w_b_zero ? 32'hFFFF_FFFF : 32'h8000_0000);

  // Multiply: sign-extend to 64 bits so a plain 64-bit product covers all four forms
  logic        w_sa, w_sb;
  logic [63:0] w_ea, w_eb, w_prod;
  logic [31:0] w_mul_res;

  assign w_sa      = (r_f3[1:0] == 2'b01) || (r_f3[1:0] == 2'b10);
  assign w_sb      = (r_f3[1:0] == 2'b01);
  assign w_ea      = {{32{w_sa & r_a[31]}}, r_a};
  assign w_eb      = {{32{w_sb & r_b[31]}}, r_b};
  assign w_prod    = w_ea * w_eb;
  assign w_mul_res = (r_f3[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];

  // One restoring step: shift next dividend bit into the partial remainder
  logic [32:0] w_shift;
  logic        w_ge;
  logic [31:0] w_sub;
  logic [31:0] w_fix_q, w_fix_r;

  assign w_shift = {r_rem, r_quo[31]};
  assign w_ge    = (w_shift >= {1'b0, r_dvs});
  assign w_sub   = w_shift[31:0] - r_dvs;
  assign w_fix_q = r_neg_q ? -r_quo : r_quo;
  assign w_fix_r = r_neg_r ? -r_rem : r_rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_f3     <= 3'd0;
      r_a      <= 32'h0;
      r_b      <= 32'h0;
      r_rem    <= 32'h0;
      r_quo    <= 32'h0;
      r_dvs    <= 32'h0;
      r_cnt    <= 5'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 32'h0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_f3    <= funct3;
            r_a     <= op_a;
            r_b     <= op_b;
            r_rem   <= 32'h0;
            r_quo   <= w_abs_a;
            r_dvs   <= w_abs_b;
            r_cnt   <= 5'd0;
            r_neg_q <= w_sgn && (op_a[31] ^ op_b[31]);
            r_neg_r <= w_sgn && op_a[31];
            if (!funct3[2]) begin
              r_state <= S_MUL;
            end else if (w_bypass) begin
              r_result <= w_byp_res;
              r_state  <= S_DONE;
            end else begin
              r_state <= S_DIV;
            end
          end
        end
        S_MUL: begin
          r_result <= w_mul_res;
          r_state  <= S_DONE;
        end
        S_DIV: begin
          r_rem <= w_ge ? w_sub : w_shift[31:0];
          r_quo <= {r_quo[30:0], w_ge};
          r_cnt <= r_cnt + 5'd1;
          if (r_cnt == 5'd31) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result <= r_f3[1] ? w_fix_r : w_fix_q;
          r_state  <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall  = w_accept || (r_state == S_MUL) || (r_state == S_DIV) || (r_state == S_FIX);
  assign done   = (r_state == S_DONE);
  assign result = r_result;

endmodule

// File: tb/tb_ex_mdu.sv
// Randomized self-checking bench for ex_mdu against an arithmetic reference model.
module tb_ex_mdu;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic        stall, done;
  logic [31:0] result;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] last_res = 32'h0;

  always #5 clk = ~clk;

  ex_mdu dut (
    .clk(clk), .rst(rst), .start(start), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .flush(flush),
    .stall(stall), .done(done), .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'h0, a});
    ub  = longint'({32'h0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (!f[2]) return 2;
    if (b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  // Issue one op in an IDLE cycle, scramble inputs while busy, then check the completion
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    int          lat, stl;
    bit          seen;
    exp  = ref_res(f, a, b);
    lat  = ref_lat(f, a, b);
    stl  = 0;
    seen = 0;
    @(negedge clk);
    chk({tag, "/hold"}, result, last_res);
    funct3 = f; op_a = a; op_b = b; start = 1'b1;
    #1;
    chk({tag, "/stall_T"}, {31'b0, stall}, 32'd1);
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        chk({tag, "/lat"}, n, lat);
        chk({tag, "/res"}, result, exp);
        chk({tag, "/stall_done"}, {31'b0, stall}, 32'd0);
        chk({tag, "/stall_cnt"}, stl, lat - 1);
        start    = 1'b0;
        last_res = exp;
      end else begin
        if (stall) stl++;
        start  = 1'($urandom_range(0, 1));
        funct3 = 3'($urandom);
        op_a   = $urandom;
        op_b   = $urandom;
      end
    end
    if (!seen) chk({tag, "/timeout"}, 32'd0, 32'd1);
    start = 1'b0;
  endtask

  // Start DIVU, then kill it with flush or reset at T+10
  task automatic abort(input string tag, input bit use_rst);
    int dn;
    @(negedge clk);
    funct3 = 3'd5; op_a = 32'd1000; op_b = 32'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(negedge clk);
    rst = 1'b0; flush = 1'b0;
    if (use_rst) last_res = 32'h0;
    chk({tag, "/stall"}, {31'b0, stall}, 32'd0);
    chk({tag, "/done"}, {31'b0, done}, 32'd0);
    chk({tag, "/res"}, result, last_res);
    dn = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dn++;
    end
    chk({tag, "/no_done"}, dn, 0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      5: return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    rst = 1'b1; start = 1'b0; flush = 1'b0;
    funct3 = 3'd0; op_a = 32'h0; op_b = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst/stall", {31'b0, stall}, 32'd0);
    chk("rst/done", {31'b0, done}, 32'd0);
    chk("rst/res", result, 32'h0);
    rst = 1'b0;

    run_op("mul",    3'd0, 32'hFFFF_FFFF, 32'd2);
    run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2);
    run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2);
    run_op("divu0",  3'd5, 32'd5, 32'd0);
    run_op("remu0",  3'd7, 32'd5, 32'd0);
    run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
    abort("flush", 1'b0);
    abort("rst", 1'b1);
    run_op("b2b_divu",  3'd5, 32'd100, 32'd7);
    run_op("b2b_mulhu", 3'd3, 32'h1234_5678, 32'h9ABC_DEF0);

    for (int i = 0; i < 60; i++) begin
      run_op("rand", 3'($urandom), pick(), pick());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
